// File: rtl/valid_generator_mii_if.sv
// FIFO read-port and AXI-Stream master signal bundle for valid_generator_mii.
// The master modport is the controller's view; slave is the FIFO/sink side.
interface valid_generator_mii_if #(
  parameter int DATA_WIDTH = 64
);
  localparam int KEEP_WIDTH = DATA_WIDTH / 8;
  localparam int FIFO_WIDTH = DATA_WIDTH + KEEP_WIDTH + 1;

  logic                  empty_flag;
  logic                  rd_rst_busy;
  logic                  rd_en;
  logic [FIFO_WIDTH-1:0] fifo_dout;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready;
  logic [DATA_WIDTH-1:0] m_axis_tdata;
  logic [KEEP_WIDTH-1:0] m_axis_tkeep;
  logic                  m_axis_tlast;
  logic [15:0]           frame_count;

  modport master (
    input  empty_flag, rd_rst_busy, fifo_dout, m_axis_tready,
    output rd_en, m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, frame_count
  );

  modport slave (
    output empty_flag, rd_rst_busy, fifo_dout, m_axis_tready,
    input  rd_en, m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, frame_count
  );
endinterface

// File: rtl/valid_generator_mii.sv
// Read-side controller for the MII-to-AXIS CDC FIFO: pops {tlast,tkeep,tdata} words,
// hides the one-cycle FIFO read latency in a 3-entry buffer and drives an AXIS master.
module valid_generator_mii #(
  parameter  int DATA_WIDTH = 64,
  localparam int KEEP_WIDTH = DATA_WIDTH / 8,
  localparam int FIFO_WIDTH = DATA_WIDTH + KEEP_WIDTH + 1
) (
  input  logic                 axis_aclk,
  input  logic                 axis_aresetn,
  valid_generator_mii_if.master bus
);

  logic [FIFO_WIDTH-1:0] fifo_buf_q [3];
  logic [1:0]            wr_ptr_q, rd_ptr_q;
  logic [1:0]            occ_q, occ_d;
  logic                  inflight_q;
  logic                  run_q;
  logic [15:0]           frame_cnt_q;

  logic                  pop;
  logic                  rd_en_c;
  logic [FIFO_WIDTH-1:0] head;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // run_q holds rd_en low throughout reset, since occ/inflight alone would allow a read.
  always_comb begin
    head    = fifo_buf_q[rd_ptr_q];
    pop     = (occ_q != 2'd0) && bus.m_axis_tready;
    rd_en_c = run_q && !bus.empty_flag && !bus.rd_rst_busy &&
              (({1'b0, occ_q} + {2'b00, inflight_q}) < 3'd3);
    occ_d   = occ_q + {1'b0, inflight_q} - {1'b0, pop};
  end

  assign bus.rd_en         = rd_en_c;
  assign bus.m_axis_tvalid = (occ_q != 2'd0);
  assign bus.m_axis_tdata  = head[DATA_WIDTH-1:0];
  assign bus.m_axis_tkeep  = head[DATA_WIDTH +: KEEP_WIDTH];
  assign bus.m_axis_tlast  = head[FIFO_WIDTH-1];
  assign bus.frame_count   = frame_cnt_q;

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      for (int unsigned i = 0; i < 3; i++) fifo_buf_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      inflight_q  <= 1'b0;
      run_q       <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      run_q      <= 1'b1;
      inflight_q <= rd_en_c;
      occ_q      <= occ_d;
      if (inflight_q) begin
        fifo_buf_q[wr_ptr_q] <= bus.fifo_dout;
        wr_ptr_q             <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
        if (head[FIFO_WIDTH-1]) frame_cnt_q <= frame_cnt_q + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_valid_generator_mii.sv
// Directed bench for valid_generator_mii: FIFO model with one-cycle read latency,
// in-order scoreboard on AXIS handshakes, and per-cycle protocol checks.
module tb_valid_generator_mii;
  localparam int DW = 64;
  localparam int KW = DW / 8;
  localparam int FW = DW + KW + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  valid_generator_mii_if #(.DATA_WIDTH(DW)) bus ();
  valid_generator_mii #(.DATA_WIDTH(DW)) dut (
    .axis_aclk   (clk),
    .axis_aresetn(rst_n),
    .bus         (bus)
  );

  // FIFO model: words become readable once pushed; data appears one cycle after rd_en.
  logic [FW-1:0] fifo_mem [$];
  int   pushed_total = 0;
  int   popped_total = 0;
  logic hold_empty = 1'b0;
  logic busy = 1'b0;
  logic tready = 1'b0;

  assign bus.empty_flag    = hold_empty || (pushed_total == popped_total);
  assign bus.rd_rst_busy   = busy;
  assign bus.m_axis_tready = tready;

  always @(posedge clk) begin
    if (bus.rd_en && (pushed_total != popped_total)) begin
      bus.fifo_dout <= fifo_mem[popped_total];
      popped_total  <= popped_total + 1;
    end
  end

  logic [FW-1:0] exp_q [$];
  int   checks = 0;
  int   errors = 0;
  int   acc_total = 0;
  int   rd_pulses = 0;
  logic [15:0] exp_fc = '0;
  logic stalled = 1'b0;
  logic [FW-1:0] stall_word;
  logic rdy_n = 1'b0, hold_n = 1'b0, busy_n = 1'b0;
  logic [FW-1:0] word, e;
  int   first_idx;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask

  task automatic push_word(input logic last, input logic [DW-1:0] d, input logic [KW-1:0] k);
    fifo_mem.push_back({last, k, d});
    exp_q.push_back({last, k, d});
    pushed_total++;
  endtask

  // One clock: apply inputs at the falling edge, then sample and score 1 time unit later.
  task automatic step();
    @(negedge clk);
    tready     = rdy_n;
    hold_empty = hold_n;
    busy       = busy_n;
    #1;
    word = {bus.m_axis_tlast, bus.m_axis_tkeep, bus.m_axis_tdata};
    chk("frame_count", bus.frame_count, exp_fc);
    chk("occupancy_le3", (popped_total - acc_total) <= 3, 1'b1);
    chk("no_overread", !(bus.rd_en && (pushed_total == popped_total)), 1'b1);
    if (bus.rd_en) rd_pulses++;
    if (stalled) begin
      chk("stall_tvalid", bus.m_axis_tvalid, 1'b1);
      chk("stall_word", word, stall_word);
    end
    if (bus.m_axis_tvalid && tready) begin
      if (exp_q.size() == 0) chk("unexpected_beat", bus.m_axis_tvalid, 1'b0);
      else begin
        e = exp_q.pop_front();
        chk("beat", word, e);
        acc_total++;
        if (e[FW-1]) exp_fc++;
      end
    end
    stalled    = bus.m_axis_tvalid && !tready;
    stall_word = word;
  endtask

  task automatic drain(input int budget);
    rdy_n = 1'b1; hold_n = 1'b0; busy_n = 1'b0;
    for (int n = 0; n < budget && exp_q.size() != 0; n++) step();
    chk("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    // Reset asserted asynchronously with a frame already waiting in the FIFO.
    push_word(1'b0, 64'h11, 8'hFF);
    push_word(1'b0, 64'h22, 8'hFF);
    push_word(1'b0, 64'h33, 8'hFF);
    push_word(1'b1, 64'h44, 8'hFF);
    #1 rst_n = 1'b0;
    #2;
    chk("rst_async_tvalid", bus.m_axis_tvalid, 1'b0);
    chk("rst_async_tdata", bus.m_axis_tdata, '0);
    repeat (3) @(negedge clk);
    #1;
    chk("rst_rd_en", bus.rd_en, 1'b0);
    chk("rst_tvalid", bus.m_axis_tvalid, 1'b0);
    chk("rst_frame_count", bus.frame_count, 16'd0);
    chk("rst_tkeep", bus.m_axis_tkeep, '0);
    chk("rst_tlast", bus.m_axis_tlast, 1'b0);

    // Release: rd_en next cycle, first beat two cycles after that, then no bubbles.
    @(negedge clk);
    rst_n = 1'b1;
    rdy_n = 1'b1;
    tready = 1'b1;
    #1 chk("release_rd_en", bus.rd_en, 1'b0);
    step();
    chk("rd_en_after_release", bus.rd_en, 1'b1);
    chk("latency_tvalid_0", bus.m_axis_tvalid, 1'b0);
    step();
    chk("latency_tvalid_1", bus.m_axis_tvalid, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stream_no_bubble", bus.m_axis_tvalid, 1'b1);
    end
    step();
    chk("stream_frame_count", bus.frame_count, 16'd1);
    chk("stream_idle", bus.m_axis_tvalid, 1'b0);

    // Backpressure: only three words may be pulled while tready is low.
    rdy_n = 1'b0;
    @(posedge clk); #1;
    rd_pulses = 0;
    for (int i = 0; i < 8; i++) push_word(i == 7, 64'hB000 + 64'(i), 8'hFF);
    repeat (10) step();
    chk("bp_read_count", rd_pulses, 3);
    chk("bp_tvalid", bus.m_axis_tvalid, 1'b1);
    chk("bp_head_word", {bus.m_axis_tlast, bus.m_axis_tkeep, bus.m_axis_tdata}, exp_q[0]);
    drain(100);

    // Random ready and random FIFO-empty gaps over 1000 beats.
    for (int i = 0; i < 1000; i++)
      push_word(($urandom % 8) == 0, {$urandom, $urandom}, 8'($urandom));
    for (int n = 0; n < 20000 && exp_q.size() != 0; n++) begin
      rdy_n  = 1'($urandom % 2);
      hold_n = ($urandom % 4) == 0;
      step();
    end
    chk("random_drained", exp_q.size(), 0);
    drain(20);

    // Busy interlock mid-stream.
    @(posedge clk); #1;
    for (int i = 0; i < 12; i++) push_word(i == 11, 64'hC000 + 64'(i), 8'h0F);
    rdy_n = 1'b1;
    repeat (4) step();
    busy_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("busy_rd_en", bus.rd_en, 1'b0);
    end
    busy_n = 1'b0;
    step();
    chk("busy_resume_rd_en", bus.rd_en, 1'b1);
    drain(100);

    // Frame counter wrap: enough single-beat frames to bring the count back to 0.
    begin
      int n;
      n = 65536 - int'(exp_fc);
      for (int i = 0; i < n; i++) push_word(1'b1, 64'(i), 8'hFF);
      drain(n * 2 + 100);
    end
    step();
    chk("fc_wrap", bus.frame_count, 16'd0);

    // Reset mid-frame: outputs clear immediately; the next unread FIFO word comes out first.
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) push_word(i == 7, 64'hD000 + 64'(i), 8'hFF);
    rdy_n = 1'b1;
    repeat (4) step();
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_tvalid", bus.m_axis_tvalid, 1'b0);
    chk("midrst_tdata", bus.m_axis_tdata, '0);
    chk("midrst_tkeep", bus.m_axis_tkeep, '0);
    chk("midrst_tlast", bus.m_axis_tlast, 1'b0);
    chk("midrst_frame_count", bus.frame_count, 16'd0);
    chk("midrst_rd_en", bus.rd_en, 1'b0);
    exp_fc    = '0;
    stalled   = 1'b0;
    first_idx = popped_total;
    acc_total = popped_total;
    exp_q.delete();
    for (int i = first_idx; i < pushed_total; i++) exp_q.push_back(fifo_mem[i]);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      if (bus.m_axis_tvalid) break;
    end
    chk("post_reset_first", {bus.m_axis_tlast, bus.m_axis_tkeep, bus.m_axis_tdata},
        fifo_mem[first_idx]);
    drain(50);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
